// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target: oversamples MDC, decodes frames, and serves a 32x16 PHY register file.
`timescale 1ns/1ps
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'h01,
  parameter int          PREAMBLE_LEN = 32,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] REG0_RST     = 16'h1140,
  parameter logic [15:0] REG1_RST     = 16'h7949,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1622
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_strobe,
  output logic [4:0]  wr_regad,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);

  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

  logic [SYNC_STAGES-1:0] mdc_sync;
  logic [SYNC_STAGES-1:0] mdio_sync;
  logic                   mdc_last;
  logic                   rise;
  logic                   bit_in;

  state_t      state;
  state_t      state_next;
  logic [4:0]  bit_cnt;
  logic [4:0]  cnt_next;
  logic [PW-1:0] pre_cnt;
  logic        op_first;
  logic        is_read;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic [15:0] commit_data;
  logic [15:0] regs [32];

  logic err_set;
  logic op_ok;
  logic snap;
  logic drive_on;
  logic drive_shift;
  logic drive_off;
  logic commit;

  function automatic logic [15:0] rst_value(input logic [4:0] idx);
    case (idx)
      5'd0:    rst_value = REG0_RST;
      5'd1:    rst_value = REG1_RST;
      5'd2:    rst_value = PHY_ID1;
      5'd3:    rst_value = PHY_ID2;
      default: rst_value = 16'h0000;
    endcase
  endfunction

  // Synchronize MDC and MDIO with equal depth so sampled data stays aligned with the MDC edge;
  // left unreset so a mid-frame reset cannot fabricate a rise event.
  always_ff @(posedge clk) begin
    mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
    mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
    mdc_last  <= mdc_sync[SYNC_STAGES-1];
  end

  assign rise        = mdc_sync[SYNC_STAGES-1] & ~mdc_last;
  assign bit_in      = mdio_sync[SYNC_STAGES-1];
  assign commit_data = {shreg[14:0], bit_in};

  // Frame decoder: advances only on MDC rise events and flags the datapath actions for that bit.
  always_comb begin
    state_next  = state;
    cnt_next    = bit_cnt;
    err_set     = 1'b0;
    op_ok       = 1'b0;
    snap        = 1'b0;
    drive_on    = 1'b0;
    drive_shift = 1'b0;
    drive_off   = 1'b0;
    commit      = 1'b0;
    if (rise) begin
      case (state)
        IDLE: begin
          if (!bit_in && pre_cnt == PW'(PREAMBLE_LEN)) state_next = ST;
        end
        ST: begin
          if (bit_in) begin
            state_next = OP;
            cnt_next   = 5'd0;
          end else begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
        OP: begin
          if (bit_cnt == 5'd0) begin
            cnt_next = 5'd1;
          end else if (op_first != bit_in) begin
            op_ok      = 1'b1;
            state_next = PHYAD;
            cnt_next   = 5'd0;
          end else begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
        PHYAD: begin
          if (bit_cnt == 5'd4) begin
            state_next = REGAD;
            cnt_next   = 5'd0;
          end else begin
            cnt_next = bit_cnt + 5'd1;
          end
        end
        REGAD: begin
          if (bit_cnt != 5'd4) begin
            cnt_next = bit_cnt + 5'd1;
          end else if (phyad != PHY_ADDR) begin
            state_next = SKIP;
            cnt_next   = 5'd18;
          end else begin
            state_next = TA;
            cnt_next   = 5'd0;
            snap       = is_read;
          end
        end
        TA: begin
          if (bit_cnt == 5'd0) begin
            if (!is_read && !bit_in) begin
              err_set    = 1'b1;
              state_next = SKIP;
              cnt_next   = 5'd17;
            end else begin
              cnt_next = 5'd1;
            end
          end else if (is_read) begin
            drive_on   = 1'b1;
            state_next = DATA;
            cnt_next   = 5'd0;
          end else if (bit_in) begin
            err_set    = 1'b1;
            state_next = SKIP;
            cnt_next   = 5'd16;
          end else begin
            state_next = DATA;
            cnt_next   = 5'd0;
          end
        end
        DATA: begin
          if (is_read) begin
            if (bit_cnt == 5'd16) begin
              drive_off  = 1'b1;
              state_next = IDLE;
            end else begin
              drive_shift = 1'b1;
              cnt_next    = bit_cnt + 5'd1;
            end
          end else if (bit_cnt == 5'd15) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = bit_cnt + 5'd1;
          end
        end
        SKIP: begin
          if (bit_cnt <= 5'd1) state_next = IDLE;
          else                 cnt_next   = bit_cnt - 5'd1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register for the frame decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  // Field capture, preamble counting, read-data drive and write-commit outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt   <= '0;
      op_first  <= 1'b0;
      is_read   <= 1'b0;
      phyad     <= 5'd0;
      regad     <= 5'd0;
      shreg     <= 16'h0000;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_regad  <= 5'd0;
      wr_data   <= 16'h0000;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= commit;
      frame_err <= err_set;
      if (state != IDLE) begin
        pre_cnt <= '0;
      end else if (rise) begin
        if (!bit_in)                            pre_cnt <= '0;
        else if (pre_cnt != PW'(PREAMBLE_LEN)) pre_cnt <= pre_cnt + 1'b1;
      end
      if (rise && state == OP && bit_cnt == 5'd0) op_first <= bit_in;
      if (op_ok) is_read <= op_first;
      if (rise && state == PHYAD) phyad <= {phyad[3:0], bit_in};
      if (rise && state == REGAD) regad <= {regad[3:0], bit_in};
      if (snap)                                     shreg <= regs[{regad[3:0], bit_in}];
      else if (drive_shift)                         shreg <= {shreg[14:0], 1'b0};
      else if (rise && state == DATA && !is_read)   shreg <= commit_data;
      if (drive_on) begin
        mdio_oe <= 1'b1;
        mdio_o  <= 1'b0;
      end
      if (drive_shift) mdio_o <= shreg[15];
      if (drive_off) begin
        mdio_oe <= 1'b0;
        mdio_o  <= 1'b1;
      end
      if (commit) begin
        wr_regad <= regad;
        wr_data  <= commit_data;
      end
    end
  end

  // Register file: regs 1-3 are fixed, and a write of BMCR bit15 restores every register.
  always_ff @(posedge clk) begin
    if (reset || (commit && regad == 5'd0 && commit_data[15])) begin
      for (int i = 0; i < 32; i++) regs[i] <= rst_value(5'(i));
    end else if (commit && (regad == 5'd0 || regad > 5'd3)) begin
      regs[regad] <= commit_data;
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: the bench plays the MAC and predicts PHY responses.
`timescale 1ns/1ps
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc = 1'b0;
  logic        tb_mdio = 1'b1;
  logic        mdio_line;
  logic        mdio_o;
  logic        mdio_oe;
  logic        wr_strobe;
  logic [4:0]  wr_regad;
  logic [15:0] wr_data;
  logic        frame_err;

  typedef struct { logic [4:0] regad; logic [15:0] data; } wr_exp_t;
  typedef struct { logic [15:0] data; bit aborted; } rd_exp_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  int          err_q[$];
  logic [15:0] ref_regs [32];
  int          checks = 0;
  int          failures = 0;

  assign mdio_line = mdio_oe ? mdio_o : tb_mdio;

  always #5 clk = ~clk;

  mdio_phy_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mdc       (mdc),
    .mdio_i    (mdio_line),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .wr_strobe (wr_strobe),
    .wr_regad  (wr_regad),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  function automatic void ref_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 16'h0000;
    ref_regs[0] = 16'h1140;
    ref_regs[1] = 16'h7949;
    ref_regs[2] = 16'h0022;
    ref_regs[3] = 16'h1622;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: actual=event required=none", name);
  endtask

  task automatic send_bit(input logic b);
    int lo;
    int hi;
    lo = 5 + $urandom_range(0, 2);
    hi = 5 + $urandom_range(0, 2);
    @(negedge clk);
    mdc     = 1'b0;
    tb_mdio = b;
    repeat (lo) @(negedge clk);
    mdc = 1'b1;
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [1:0] ta, input logic [15:0] data, input bit released, input int n_data);
    repeat (pre) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 1; i >= 0; i--) send_bit(op[i]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(rg[i]);
    for (int i = 1; i >= 0; i--) send_bit(released ? 1'b1 : ta[i]);
    for (int i = 15; i > 15 - n_data; i--) send_bit(released ? 1'b1 : data[i]);
  endtask

  task automatic apply_stimulus(input bit rd, input logic [4:0] phy, input logic [4:0] rg,
                                input logic [15:0] data, input int pre);
    if (phy == 5'h01) begin
      if (rd) begin
        rd_q.push_back('{data: ref_regs[rg], aborted: 1'b0});
      end else begin
        wr_q.push_back('{regad: rg, data: data});
        if (rg == 5'd0 && data[15]) ref_reset();
        else if (rg == 5'd0 || rg > 5'd3) ref_regs[rg] = data;
      end
    end
    send_frame(pre, rd ? 2'b10 : 2'b01, phy, rg, rd ? 2'b11 : 2'b10, data, rd, 16);
    if (rd) send_bit(1'b1);
  endtask

  // Write and error monitor: every strobe or error pulse must match a queued expectation.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        if (wr_q.size() == 0) flag_unexpected("wr_strobe");
        else begin
          e = wr_q.pop_front();
          check_output("wr_regad", 32'(wr_regad), 32'(e.regad));
          check_output("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) flag_unexpected("frame_err");
        else begin
          void'(err_q.pop_front());
          check_output("frame_err", 32'(frame_err), 32'd1);
        end
      end
    end
  end

  // Read monitor: samples the line mid-bit like a MAC and checks each completed drive window.
  initial begin
    int          n;
    logic        ta_bit;
    logic [15:0] d;
    bit          cap;
    rd_exp_t     e;
    cap    = 1'b0;
    n      = 0;
    ta_bit = 1'b1;
    d      = 16'h0000;
    forever begin
      @(negedge mdc);
      if (mdio_oe) begin
        if (!cap) begin
          cap    = 1'b1;
          n      = 1;
          ta_bit = mdio_line;
          d      = 16'h0000;
        end else begin
          n++;
          d = {d[14:0], mdio_line};
        end
      end else if (cap) begin
        cap = 1'b0;
        if (rd_q.size() == 0) flag_unexpected("mdio_oe");
        else begin
          e = rd_q.pop_front();
          if (e.aborted) begin
            check_output("aborted_read_short", 32'(n < 17), 32'd1);
          end else begin
            check_output("ta_bit", 32'(ta_bit), 32'd0);
            check_output("oe_periods", 32'(n), 32'd17);
            check_output("read_data", 32'(d), 32'(e.data));
          end
        end
      end
    end
  end

  // Stimulus: directed frames for the boundary cases, then randomized well-formed traffic.
  initial begin
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    bit          rd;
    ref_reset();
    repeat (4) @(negedge clk);
    check_output("reset_oe", 32'(mdio_oe), 32'd0);
    check_output("reset_o", 32'(mdio_o), 32'd1);
    check_output("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check_output("reset_frame_err", 32'(frame_err), 32'd0);
    check_output("reset_wr_regad", 32'(wr_regad), 32'd0);
    check_output("reset_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;

    apply_stimulus(1'b0, 5'd1, 5'd0, 16'h3100, 32);
    apply_stimulus(1'b1, 5'd1, 5'd0, 16'h0000, 32);
    apply_stimulus(1'b1, 5'd1, 5'd1, 16'h0000, 33);
    apply_stimulus(1'b0, 5'd1, 5'd1, 16'hFFFF, 32);
    apply_stimulus(1'b1, 5'd1, 5'd1, 16'h0000, 32);
    apply_stimulus(1'b0, 5'd2, 5'd4, 16'h1234, 32);
    apply_stimulus(1'b1, 5'd1, 5'd4, 16'h0000, 32);

    send_frame(31, 2'b10, 5'd1, 5'd2, 2'b11, 16'h0000, 1'b1, 16);
    send_bit(1'b1);
    send_bit(1'b0);
    apply_stimulus(1'b1, 5'd1, 5'd2, 16'h0000, 32);

    err_q.push_back(1);
    send_frame(32, 2'b11, 5'd1, 5'd4, 2'b10, 16'h5555, 1'b0, 16);
    send_bit(1'b0);

    apply_stimulus(1'b0, 5'd1, 5'd4, 16'hABCD, 32);
    err_q.push_back(1);
    send_frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'h1111, 1'b0, 16);
    apply_stimulus(1'b1, 5'd1, 5'd4, 16'h0000, 32);

    apply_stimulus(1'b0, 5'd1, 5'd0, 16'h8000, 32);
    apply_stimulus(1'b1, 5'd1, 5'd0, 16'h0000, 32);
    apply_stimulus(1'b1, 5'd1, 5'd4, 16'h0000, 32);

    apply_stimulus(1'b0, 5'd1, 5'd5, 16'h0A5A, 32);
    rd_q.push_back('{data: 16'h0000, aborted: 1'b1});
    send_frame(32, 2'b10, 5'd1, 5'd5, 2'b11, 16'h0000, 1'b1, 8);
    check_output("oe_before_reset", 32'(mdio_oe), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("oe_after_reset", 32'(mdio_oe), 32'd0);
    check_output("o_after_reset", 32'(mdio_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    apply_stimulus(1'b1, 5'd1, 5'd5, 16'h0000, 32);
    apply_stimulus(1'b1, 5'd1, 5'd3, 16'h0000, 32);

    for (int k = 0; k < 25; k++) begin
      rd   = 1'($urandom_range(0, 1));
      phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
      rg   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      data = 16'($urandom);
      if (rg == 5'd0 && $urandom_range(0, 3) != 0) data[15] = 1'b0;
      apply_stimulus(rd, phy, rg, data, 32 + $urandom_range(0, 2));
    end

    repeat (3) send_bit(1'b1);
    repeat (20) @(negedge clk);
    check_output("pending_writes", 32'(wr_q.size()), 32'd0);
    check_output("pending_reads", 32'(rd_q.size()), 32'd0);
    check_output("pending_errors", 32'(err_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Watchdog bounding the whole run.
  initial begin
    #900000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog: actual=timeout required=completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
